// File: rtl/arrow_overlay.sv
// Arrow icon overlay: places, bobs, flashes and colours a 64x64 sprite on the scan stream.
// Optional blink behaviour is built when ARROW_BLINK_EN is defined.
module arrow_overlay #(
  parameter logic [10:0] X0           = 11'd288,
  parameter logic [10:0] Y0           = 11'd200,
  parameter logic [5:0]  BOB_AMP      = 6'd8,
  parameter logic [7:0]  PRESS_FRAMES = 8'd12,
  parameter logic [11:0] FG_COLOR     = 12'hFF0,
  parameter logic [11:0] FLASH_COLOR  = 12'hF00
`ifdef ARROW_BLINK_EN
  , parameter logic [5:0] BLINK_FRAMES = 6'd16
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcnt,
  input  logic [10:0] vcnt,
  input  logic        video_on,
  input  logic        frame_tick,
  input  logic        show,
  input  logic        press,
  output logic [10:0] ix,
  output logic [10:0] iy,
  input  logic        mask,
  output logic [11:0] rgb,
  output logic        hit,
  output logic        done
);

  typedef enum logic [1:0] {
    HIDDEN   = 2'd0,
    BOB_DOWN = 2'd1,
    BOB_UP   = 2'd2,
    FLASH    = 2'd3
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [5:0]  off_r, off_nxt_s;
  logic [7:0]  fcnt_r, fcnt_nxt_s;
  logic        done_nxt_s;
  logic        vis_s;

  logic [10:0] ix_r, iy_r;
  logic        in1_r, von1_r;
  logic [11:0] rgb_r;
  logic        hit_r, done_r;

  logic [10:0] dx_s, dy_s;
  logic        draw_s;
  logic [11:0] color_s;

  // Control FSM next-state: show/hide, frame-locked bob, press flash countdown.
  always_comb begin
    state_nxt_s = state_r;
    off_nxt_s   = off_r;
    fcnt_nxt_s  = fcnt_r;
    done_nxt_s  = 1'b0;
    case (state_r)
      HIDDEN: begin
        if (show) begin
          state_nxt_s = BOB_DOWN;
          off_nxt_s   = 6'd0;
        end else begin
          state_nxt_s = HIDDEN;
        end
      end
      BOB_DOWN: begin
        if (!show) begin
          state_nxt_s = HIDDEN;
        end else if (press) begin
          state_nxt_s = FLASH;
          fcnt_nxt_s  = PRESS_FRAMES - 8'd1;
        end else if (frame_tick) begin
          off_nxt_s = off_r + 6'd1;
          if (off_nxt_s == BOB_AMP) begin
            state_nxt_s = BOB_UP;
          end else begin
            state_nxt_s = BOB_DOWN;
          end
        end else begin
          state_nxt_s = BOB_DOWN;
        end
      end
      BOB_UP: begin
        if (!show) begin
          state_nxt_s = HIDDEN;
        end else if (press) begin
          state_nxt_s = FLASH;
          fcnt_nxt_s  = PRESS_FRAMES - 8'd1;
        end else if (frame_tick) begin
          off_nxt_s = off_r - 6'd1;
          if (off_nxt_s == 6'd0) begin
            state_nxt_s = BOB_DOWN;
          end else begin
            state_nxt_s = BOB_UP;
          end
        end else begin
          state_nxt_s = BOB_UP;
        end
      end
      FLASH: begin
        if (frame_tick) begin
          if (fcnt_r == 8'd0) begin
            state_nxt_s = HIDDEN;
            done_nxt_s  = 1'b1;
          end else begin
            fcnt_nxt_s = fcnt_r - 8'd1;
          end
        end else begin
          state_nxt_s = FLASH;
        end
      end
      default: begin
        state_nxt_s = HIDDEN;
        off_nxt_s   = 6'd0;
        fcnt_nxt_s  = 8'd0;
      end
    endcase
  end

  // Control FSM state, bob offset, flash counter and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= HIDDEN;
      off_r   <= 6'd0;
      fcnt_r  <= 8'd0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      off_r   <= off_nxt_s;
      fcnt_r  <= fcnt_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

`ifdef ARROW_BLINK_EN
  logic [5:0] blink_cnt_r, blink_cnt_nxt_s;
  logic       blink_vis_r, blink_vis_nxt_s;

  // Blink phase: counts 1..BLINK_FRAMES while bobbing, held at visible otherwise.
  always_comb begin
    blink_cnt_nxt_s = blink_cnt_r;
    blink_vis_nxt_s = blink_vis_r;
    if ((state_r == BOB_DOWN) || (state_r == BOB_UP)) begin
      if (frame_tick) begin
        if (blink_cnt_r == BLINK_FRAMES) begin
          blink_cnt_nxt_s = 6'd1;
          blink_vis_nxt_s = ~blink_vis_r;
        end else begin
          blink_cnt_nxt_s = blink_cnt_r + 6'd1;
        end
      end else begin
        blink_cnt_nxt_s = blink_cnt_r;
      end
    end else begin
      blink_cnt_nxt_s = 6'd1;
      blink_vis_nxt_s = 1'b1;
    end
  end

  // Blink phase registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_r <= 6'd0;
      blink_vis_r <= 1'b0;
    end else begin
      blink_cnt_r <= blink_cnt_nxt_s;
      blink_vis_r <= blink_vis_nxt_s;
    end
  end

  assign vis_s = (state_r != HIDDEN) & blink_vis_r;
`else
  assign vis_s = (state_r != HIDDEN);
`endif

  // Sprite-relative coordinates; negative results wrap high and fall outside the box.
  assign dx_s    = hcnt - X0;
  assign dy_s    = vcnt - Y0 - {5'd0, off_r};
  assign draw_s  = in1_r & von1_r & mask & vis_s;
  assign color_s = (state_r == FLASH) ? FLASH_COLOR : FG_COLOR;

  // Stage 1: ROM address and in-box / visible-area flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      ix_r   <= 11'd0;
      iy_r   <= 11'd0;
      in1_r  <= 1'b0;
      von1_r <= 1'b0;
    end else begin
      ix_r   <= dx_s;
      iy_r   <= dy_s;
      in1_r  <= (dx_s < 11'd64) && (dy_s < 11'd64);
      von1_r <= video_on;
    end
  end

  // Stage 2: pixel colour and hit flag from the ROM mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_r <= 12'h000;
      hit_r <= 1'b0;
    end else begin
      rgb_r <= draw_s ? color_s : 12'h000;
      hit_r <= draw_s;
    end
  end

  assign ix   = ix_r;
  assign iy   = iy_r;
  assign rgb  = rgb_r;
  assign hit  = hit_r;
  assign done = done_r;

endmodule

// File: tb/tb_arrow_overlay.sv
// Scoreboard bench for arrow_overlay: directed pixels, bob, flash and reset scenarios.
module tb_arrow_overlay;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcnt, vcnt;
  logic        video_on, frame_tick, show, press, mask;
  logic [10:0] ix, iy;
  logic [11:0] rgb;
  logic        hit, done;

  always #5 clk = ~clk;

  arrow_overlay dut (
    .clk(clk), .rst(rst), .hcnt(hcnt), .vcnt(vcnt), .video_on(video_on),
    .frame_tick(frame_tick), .show(show), .press(press),
    .ix(ix), .iy(iy), .mask(mask), .rgb(rgb), .hit(hit), .done(done)
  );

  typedef struct {
    logic [10:0] ix;
    logic [10:0] iy;
    logic [11:0] rgb;
    logic        hit;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e_mon;
  int   n_vec = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  logic issue = 1'b0, p1 = 1'b0, p2 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Track which issued pixels have reached stage 1 and stage 2.
  always @(posedge clk) begin
    p1 <= issue;
    p2 <= p1;
  end

  // Monitor: pop and compare expected values as each pipeline stage presents them.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (p1) begin
      if (q1.size() == 0) check("q1_underflow", 32'd1, 32'd0);
      else begin
        e_mon = q1.pop_front();
        check("ix", {21'd0, ix}, {21'd0, e_mon.ix});
        check("iy", {21'd0, iy}, {21'd0, e_mon.iy});
      end
    end
    if (p2) begin
      if (q2.size() == 0) check("q2_underflow", 32'd1, 32'd0);
      else begin
        e_mon = q2.pop_front();
        check("rgb", {20'd0, rgb}, {20'd0, e_mon.rgb});
        check("hit", {31'd0, hit}, {31'd0, e_mon.hit});
      end
    end
  end

  task automatic pix(input logic [10:0] h, input logic [10:0] v, input logic vo, input logic m,
                     input logic [10:0] eix, input logic [10:0] eiy,
                     input logic [11:0] ergb, input logic ehit);
    exp_t e;
    e.ix = eix; e.iy = eiy; e.rgb = ergb; e.hit = ehit;
    q1.push_back(e);
    q2.push_back(e);
    hcnt = h; vcnt = v; video_on = vo; mask = m; issue = 1'b1;
    @(negedge clk);
    hcnt = 11'd0; vcnt = 11'd0; video_on = 1'b0; issue = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mask = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse_press();
    press = 1'b1;
    @(negedge clk);
    press = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; hcnt = 11'd0; vcnt = 11'd0; video_on = 1'b0; frame_tick = 1'b0;
    show = 1'b0; press = 1'b0; mask = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ix", {21'd0, ix}, 32'd0);
    check("rst_iy", {21'd0, iy}, 32'd0);
    check("rst_rgb", {20'd0, rgb}, 32'd0);
    check("rst_hit", {31'd0, hit}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    show = 1'b1;
    @(negedge clk);

`ifdef ARROW_BLINK_EN
    pix(11'd288, 11'd200, 1'b1, 1'b1, 11'd0, 11'd0, 12'hFF0, 1'b1);
    ticks(15);
    pix(11'd288, 11'd201, 1'b1, 1'b1, 11'd0, 11'd0, 12'hFF0, 1'b1);
    ticks(1);
    pix(11'd288, 11'd200, 1'b1, 1'b1, 11'd0, 11'd0, 12'h000, 1'b0);
    ticks(15);
    pix(11'd288, 11'd201, 1'b1, 1'b1, 11'd0, 11'd0, 12'h000, 1'b0);
    ticks(1);
    pix(11'd288, 11'd200, 1'b1, 1'b1, 11'd0, 11'd0, 12'hFF0, 1'b1);
    ticks(20);
    pix(11'd288, 11'd204, 1'b1, 1'b1, 11'd0, 11'd0, 12'h000, 1'b0);
    pulse_press();
    pix(11'd288, 11'd204, 1'b1, 1'b1, 11'd0, 11'd0, 12'hF00, 1'b1);
    ticks(3);
    pix(11'd288, 11'd204, 1'b1, 1'b1, 11'd0, 11'd0, 12'hF00, 1'b1);
`else
    // In-box corners, out-of-box edges, mask and video_on gating at off=0.
    pix(11'd288, 11'd200, 1'b1, 1'b1, 11'd0,    11'd0,  12'hFF0, 1'b1);
    pix(11'd287, 11'd200, 1'b1, 1'b1, 11'd2047, 11'd0,  12'h000, 1'b0);
    pix(11'd352, 11'd200, 1'b1, 1'b1, 11'd64,   11'd0,  12'h000, 1'b0);
    pix(11'd351, 11'd263, 1'b1, 1'b1, 11'd63,   11'd63, 12'hFF0, 1'b1);
    pix(11'd300, 11'd210, 1'b1, 1'b0, 11'd12,   11'd10, 12'h000, 1'b0);
    pix(11'd300, 11'd210, 1'b0, 1'b1, 11'd12,   11'd10, 12'h000, 1'b0);
    // Bob: down to 8, back up to 0, then down again.
    ticks(3);
    pix(11'd288, 11'd203, 1'b1, 1'b1, 11'd0, 11'd0,    12'hFF0, 1'b1);
    pix(11'd288, 11'd200, 1'b1, 1'b1, 11'd0, 11'd2045, 12'h000, 1'b0);
    ticks(5);
    pix(11'd288, 11'd208, 1'b1, 1'b1, 11'd0, 11'd0, 12'hFF0, 1'b1);
    ticks(1);
    pix(11'd288, 11'd207, 1'b1, 1'b1, 11'd0, 11'd0, 12'hFF0, 1'b1);
    ticks(7);
    pix(11'd288, 11'd200, 1'b1, 1'b1, 11'd0, 11'd0, 12'hFF0, 1'b1);
    ticks(1);
    pix(11'd288, 11'd201, 1'b1, 1'b1, 11'd0, 11'd0, 12'hFF0, 1'b1);
    ticks(2);
    // Press at off=3: flash colour, frozen offset, done on the 12th tick.
    pulse_press();
    pix(11'd288, 11'd203, 1'b1, 1'b1, 11'd0, 11'd0, 12'hF00, 1'b1);
    ticks(5);
    show = 1'b0;
    ticks(6);
    check("no_done_early", done_cnt, 32'd0);
    pix(11'd288, 11'd203, 1'b1, 1'b1, 11'd0, 11'd0, 12'hF00, 1'b1);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check("done_pulse", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("done_low", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    check("done_once", done_cnt, 32'd1);
    pix(11'd288, 11'd203, 1'b1, 1'b1, 11'd0, 11'd0, 12'h000, 1'b0);
    // Press while hidden is ignored; showing restarts at off=0.
    pulse_press();
    show = 1'b1;
    @(negedge clk);
    pix(11'd288, 11'd200, 1'b1, 1'b1, 11'd0, 11'd0, 12'hFF0, 1'b1);
    // Hide wins over a simultaneous press.
    ticks(2);
    press = 1'b1; show = 1'b0;
    @(negedge clk);
    press = 1'b0;
    @(negedge clk);
    pix(11'd288, 11'd202, 1'b1, 1'b1, 11'd0, 11'd0, 12'h000, 1'b0);
    ticks(13);
    check("no_done_hide", done_cnt, 32'd1);
    // Reset mid-line blanks the output on the next edge.
    show = 1'b1;
    @(negedge clk);
    hcnt = 11'd288; vcnt = 11'd200; video_on = 1'b1; mask = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rgb", {20'd0, rgb}, 32'd0);
    check("midrst_hit", {31'd0, hit}, 32'd0);
    check("midrst_ix", {21'd0, ix}, 32'd0);
    check("midrst_iy", {21'd0, iy}, 32'd0);
    rst = 1'b0; hcnt = 11'd0; vcnt = 11'd0; video_on = 1'b0; mask = 1'b0;
    @(negedge clk);
    pix(11'd288, 11'd200, 1'b1, 1'b1, 11'd0, 11'd0, 12'hFF0, 1'b1);
`endif

    repeat (4) @(negedge clk);
    check("q1_drained", q1.size(), 32'd0);
    check("q2_drained", q2.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/arrow_overlay.md
# arrow_overlay

Placement, animation and colour stage for the 64x64 arrow icon on the title/replay screen. It sits between the VGA timing generator and the arrow mask ROM. From the scan counters and the animated sprite position it produces the sprite-relative coordinates `ix`/`iy` that drive the ROM. It then takes the ROM's `mask` back and produces a registered 12-bit pixel colour plus a hit flag for the frame compositor. A small state machine shows the icon, bobs it vertically once per frame, flashes it on a button press, and then reports completion.

## Interface
- `X0`, 288: left edge of the sprite in screen pixels.
- `Y0`, 200: top edge of the sprite at zero bob offset.
- `BOB_AMP`, 8: maximum downward bob offset in lines; legal range 1..63.
- `PRESS_FRAMES`, 12: length of the flash after a press, in frames; minimum 1.
- `BLINK_FRAMES`, 16: blink half-period in frames; used only with `ARROW_BLINK_EN`.
- `FG_COLOR`, 12'hFF0: normal icon colour.
- `FLASH_COLOR`, 12'hF00: icon colour during the press flash.

Ports:
- `clk` in 1: pixel clock.
- `rst` in 1: synchronous, active-high reset.
- `hcnt` in 11: current scan column.
- `vcnt` in 11: current scan line.
- `video_on` in 1: the current pixel is in the visible area.
- `frame_tick` in 1: one-cycle pulse at the start of vertical blank.
- `show` in 1: level input; request that the icon be displayed.
- `press` in 1: one-cycle pulse from the debounced flap button.
- `ix` out 11: registered sprite-relative column, fed to the ROM.
- `iy` out 11: registered sprite-relative row, fed to the ROM.
- `mask` in 1: ROM output for the current `ix`/`iy`.
- `rgb` out 12: registered pixel colour, 4:4:4; 12'h000 where the icon is not drawn.
- `hit` out 1: registered; high where `rgb` carries icon colour.
- `done` out 1: one-cycle pulse when the press flash completes.

## Operation
- States:
  - HIDDEN: reset state.
  - BOB_DOWN.
  - BOB_UP.
  - FLASH.
- Transitions, evaluated on every clock:
  - HIDDEN -> BOB_DOWN when `show`=1; `off` is cleared to 0.
  - BOB_DOWN / BOB_UP -> HIDDEN when `show`=0. Hiding takes priority over a simultaneous `press`.
  - BOB_DOWN / BOB_UP -> FLASH on `press`. `fcnt` is loaded with PRESS_FRAMES-1 and `off` is frozen.
  - FLASH -> HIDDEN on the `frame_tick` where `fcnt`=0. `done` pulses for one cycle on that tick. In FLASH, `show` and `press` are ignored.
- Bob counter `off` (6 bits) changes only on `frame_tick`, so no frame tears:
  - BOB_DOWN: `off` +1 per tick; on the tick where `off` reaches BOB_AMP the state becomes BOB_UP.
  - BOB_UP: `off` -1 per tick; on the tick where `off` reaches 0 the state becomes BOB_DOWN.
  - `off` always stays within 0..BOB_AMP.
- Coordinate stage (stage 1, registered):
  - `ix` <= `hcnt` - X0 and `iy` <= `vcnt` - (Y0 + `off`), computed modulo 2^11. Underflow wraps to a large value, which the ROM already treats as out of range.
  - `in1` <= (`hcnt` - X0) < 64 and (`vcnt` - Y0 - `off`) < 64, both compared as unsigned 11-bit values.
  - `von1` <= `video_on`.
- Colour stage (stage 2, registered), with `draw` = `in1` & `von1` & `mask` & `vis`:
  - `hit` <= `draw`.
  - `rgb` <= `draw` ? (state==FLASH ? FLASH_COLOR : FG_COLOR) : 12'h000.
- `vis` is 0 in HIDDEN and 1 in every other state (see Configuration for the blink case).
- `press` while HIDDEN is ignored.

## Timing
- Reset values:
  - State HIDDEN; `off`=0, `fcnt`=0.
  - `ix`=0, `iy`=0.
  - `rgb`=12'h000, `hit`=0, `done`=0.
  - All pipeline registers 0.
- Latency: a pixel's `hcnt`/`vcnt` appear on `ix`/`iy` 1 cycle later and on `rgb`/`hit` 2 cycles later. The timing generator delays sync by 2 cycles to match.
- `mask` is sampled in the same cycle that `ix`/`iy` are valid. The ROM row register needs `iy` stable for 1 cycle; this holds because X0 ≥ 1 keeps the sprite off column 0.
- State and `off` update on the clock edge that samples `frame_tick`/`press`, so the new position applies to the next pixel.
- `rst` mid-frame: outputs return to the reset values on the next edge, and `rgb` is black from that edge on.

## Configuration
- `ARROW_BLINK_EN` defined:
  - A 6-bit frame counter runs in BOB_DOWN and BOB_UP.
  - `vis` toggles every BLINK_FRAMES `frame_tick`s, starting visible.
  - The counter and `vis` are forced to 1 on entry to BOB_DOWN from HIDDEN and throughout FLASH.
- Not defined: the counter is not built, and `vis` is 1 in every state except HIDDEN.

## Test plan
- Reset, then `show`=1 and a pixel at (288,200) with `mask`=1 → `ix`=0 and `iy`=0 one cycle later; `rgb`=12'hFF0 and `hit`=1 two cycles later.
- Pixel at (287,200) or (352,200) → `in1`=0 and `rgb`=12'h000, even when `mask`=1.
- 8 `frame_tick`s → `off`=8 and state BOB_UP; pixel (288,208) gives `iy`=0. After 8 more ticks `off`=0 and the state is BOB_DOWN.
- `press` in BOB_DOWN with `off`=3 → colour 12'hF00 and `off` held at 3; `done` pulses on the 12th `frame_tick`, and the state is then HIDDEN with `rgb`=12'h000.
- `press` and `show`=0 in the same cycle → HIDDEN and no `done`; `rst` asserted mid-line → `rgb`=0 and `hit`=0 on the next edge.
- `ARROW_BLINK_EN` build → icon visible for 16 frames, hidden for 16, visible again; always visible during FLASH.
